// File: rtl/temperature_monitor_if.sv
// Sample/alarm bundle between the sensor sequencer (master) and the
// temperature monitor (slave). With TEMP_STICKY_ALARM_EN defined the bundle
// also carries the sticky alarm flags and their acknowledge mask.
interface temperature_monitor_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                sampleValid;
  logic [3:0]          sampleChannel;
  logic [WIDTH-1:0]    temperature;
  logic [CHANNELS-1:0] alarm;
  logic [CHANNELS-1:0] alarmHigh;
  logic                anyAlarm;
  logic                sampleError;
`ifdef TEMP_STICKY_ALARM_EN
  logic [CHANNELS-1:0] stickyAlarm;
  logic [CHANNELS-1:0] ackMask;
`endif

  modport master (
    output sampleValid, sampleChannel, temperature,
`ifdef TEMP_STICKY_ALARM_EN
    output ackMask,
    input  stickyAlarm,
`endif
    input  alarm, alarmHigh, anyAlarm, sampleError
  );

  modport slave (
    input  sampleValid, sampleChannel, temperature,
`ifdef TEMP_STICKY_ALARM_EN
    input  ackMask,
    output stickyAlarm,
`endif
    output alarm, alarmHigh, anyAlarm, sampleError
  );
endinterface

// File: rtl/temperature_monitor.sv
// Multi-channel body-temperature supervisor. Tagged samples (at most one per
// cycle) are range-checked; each channel runs a persistence/hysteresis FSM
// and drives registered alarm and alarm-cause flags.
// Optional feature macro: TEMP_STICKY_ALARM_EN adds per-channel sticky alarm
// flags that latch on alarm rise and clear on acknowledge once the alarm is gone.
module temperature_monitor #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int LOW_LIMIT  = 35,
  parameter int HIGH_LIMIT = 39,
  parameter int HYST       = 1,
  parameter int PERSIST    = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  temperature_monitor_if.slave bus
);

  typedef enum logic [1:0] {NORMAL, PEND_ALARM, ALARM, PEND_CLEAR} state_t;

  localparam logic [WIDTH-1:0] LOW_T     = WIDTH'(LOW_LIMIT);
  localparam logic [WIDTH-1:0] HIGH_T    = WIDTH'(HIGH_LIMIT);
  localparam logic [WIDTH-1:0] CLR_LO_T  = WIDTH'(LOW_LIMIT + HYST);
  localparam logic [WIDTH-1:0] CLR_HI_T  = WIDTH'(HIGH_LIMIT - HYST);
  localparam logic [3:0]       PERSIST_C = 4'(PERSIST);

  // Parameter sanity: an empty clear band would make alarms impossible to clear.
  if (HIGH_LIMIT - HYST < LOW_LIMIT + HYST) begin : g_bad_band
    $fatal(1, "temperature_monitor: clear band is empty (HIGH_LIMIT-HYST < LOW_LIMIT+HYST)");
  end
  if (PERSIST < 1 || PERSIST > 15) begin : g_bad_persist
    $fatal(1, "temperature_monitor: PERSIST must be 1..15");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $fatal(1, "temperature_monitor: CHANNELS must be 1..16");
  end

  // Shared sample classification; every channel sees the same sample.
  logic is_high;
  logic abn;
  logic clr;
  assign is_high = bus.temperature > HIGH_T;
  assign abn     = is_high || (bus.temperature < LOW_T);
  assign clr     = (bus.temperature >= CLR_LO_T) && (bus.temperature <= CLR_HI_T);

  logic [CHANNELS-1:0] alarm_vec;
  logic [CHANNELS-1:0] high_vec;
  logic [CHANNELS-1:0] alarm_next_vec;
  logic                any_alarm_reg;
  logic                sample_error_reg;
`ifdef TEMP_STICKY_ALARM_EN
  logic [CHANNELS-1:0] sticky_vec;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_inc;
    logic       alarm_reg;
    logic       high_reg;
    logic       alarm_next;
    logic       hit;

    assign hit     = bus.sampleValid && (bus.sampleChannel == 4'(gi));
    assign cnt_inc = cnt_reg + 4'd1;

    // Alarm value after this edge; feeds anyAlarm and the sticky rise detect.
    always_comb begin
      alarm_next = alarm_reg;
      if (hit) begin
        case (state_reg)
          NORMAL:     alarm_next = abn && (PERSIST == 1);
          PEND_ALARM: alarm_next = abn && (cnt_inc == PERSIST_C);
          ALARM:      alarm_next = !(clr && (PERSIST == 1));
          PEND_CLEAR: alarm_next = !(clr && (cnt_inc == PERSIST_C));
          default:    alarm_next = 1'b0;
        endcase
      end
    end

    // Per-channel persistence/hysteresis FSM with registered alarm outputs.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_reg <= NORMAL;
        cnt_reg   <= 4'd0;
        alarm_reg <= 1'b0;
        high_reg  <= 1'b0;
      end else if (hit) begin
        case (state_reg)
          NORMAL: begin
            if (abn) begin
              cnt_reg <= 4'd1;
              if (PERSIST == 1) begin
                state_reg <= ALARM;
                alarm_reg <= 1'b1;
                high_reg  <= is_high;
              end else begin
                state_reg <= PEND_ALARM;
              end
            end else begin
              cnt_reg <= 4'd0;
            end
          end
          PEND_ALARM: begin
            if (abn) begin
              cnt_reg <= cnt_inc;
              if (cnt_inc == PERSIST_C) begin
                state_reg <= ALARM;
                alarm_reg <= 1'b1;
                high_reg  <= is_high;
              end
            end else begin
              state_reg <= NORMAL;
              cnt_reg   <= 4'd0;
            end
          end
          ALARM: begin
            if (clr) begin
              cnt_reg <= 4'd1;
              if (PERSIST == 1) begin
                state_reg <= NORMAL;
                alarm_reg <= 1'b0;
                high_reg  <= 1'b0;
              end else begin
                state_reg <= PEND_CLEAR;
              end
            end else begin
              // abn keeps the alarm but lets the cause flip high/low
              cnt_reg <= 4'd0;
              if (abn) high_reg <= is_high;
            end
          end
          PEND_CLEAR: begin
            if (clr) begin
              cnt_reg <= cnt_inc;
              if (cnt_inc == PERSIST_C) begin
                state_reg <= NORMAL;
                alarm_reg <= 1'b0;
                high_reg  <= 1'b0;
              end
            end else begin
              state_reg <= ALARM;
              cnt_reg   <= 4'd0;
              if (abn) high_reg <= is_high;
            end
          end
          default: begin
            state_reg <= NORMAL;
            cnt_reg   <= 4'd0;
            alarm_reg <= 1'b0;
            high_reg  <= 1'b0;
          end
        endcase
      end
    end

    assign alarm_vec[gi]      = alarm_reg;
    assign high_vec[gi]       = high_reg;
    assign alarm_next_vec[gi] = alarm_next;

`ifdef TEMP_STICKY_ALARM_EN
    logic sticky_reg;
    // Sticky flag: set on alarm rise (wins over ack), cleared by ack once alarm is low.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sticky_reg <= 1'b0;
      end else if (alarm_next && !alarm_reg) begin
        sticky_reg <= 1'b1;
      end else if (bus.ackMask[gi] && !alarm_reg) begin
        sticky_reg <= 1'b0;
      end
    end
    assign sticky_vec[gi] = sticky_reg;
`endif
  end

  // Summary alarm and out-of-range tag pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_alarm_reg    <= 1'b0;
      sample_error_reg <= 1'b0;
    end else begin
      any_alarm_reg    <= |alarm_next_vec;
      sample_error_reg <= bus.sampleValid && ({1'b0, bus.sampleChannel} >= 5'(CHANNELS));
    end
  end

  assign bus.alarm       = alarm_vec;
  assign bus.alarmHigh   = high_vec;
  assign bus.anyAlarm    = any_alarm_reg;
  assign bus.sampleError = sample_error_reg;
`ifdef TEMP_STICKY_ALARM_EN
  assign bus.stickyAlarm = sticky_vec;
`endif

endmodule

// File: tb/tb_temperature_monitor.sv
// Bench for temperature_monitor: directed test-plan sequences followed by
// random samples, all checked against a streak-counting reference model.
module tb_temperature_monitor;
  localparam int WIDTH      = 8;
  localparam int CHANNELS   = 4;
  localparam int LOW_LIMIT  = 35;
  localparam int HIGH_LIMIT = 39;
  localparam int HYST       = 1;
  localparam int PERSIST    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  temperature_monitor_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  temperature_monitor #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .LOW_LIMIT(LOW_LIMIT),
    .HIGH_LIMIT(HIGH_LIMIT), .HYST(HYST), .PERSIST(PERSIST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model: alarm flag, cause, and length of the current qualifying streak.
  logic [CHANNELS-1:0] m_alarm;
  logic [CHANNELS-1:0] m_high;
  int                  m_run [CHANNELS];
  logic                m_err;
`ifdef TEMP_STICKY_ALARM_EN
  logic [CHANNELS-1:0] m_sticky;
  logic [CHANNELS-1:0] ack_drive = '0;
`endif

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_alarm = '0;
    m_high  = '0;
    m_err   = 1'b0;
    for (int c = 0; c < CHANNELS; c++) m_run[c] = 0;
`ifdef TEMP_STICKY_ALARM_EN
    m_sticky = '0;
`endif
  endtask

  // Streak rule: PERSIST consecutive abnormal samples raise, PERSIST consecutive
  // clear-band samples drop; any other sample breaks the streak.
  task automatic model_sample(input int ch, input int t);
    bit abn, clr;
    abn = (t > HIGH_LIMIT) || (t < LOW_LIMIT);
    clr = (t >= LOW_LIMIT + HYST) && (t <= HIGH_LIMIT - HYST);
    if (!m_alarm[ch]) begin
      if (abn) begin
        m_run[ch]++;
        if (m_run[ch] == PERSIST) begin
          m_alarm[ch] = 1'b1;
          m_high[ch]  = (t > HIGH_LIMIT);
          m_run[ch]   = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
    end else begin
      if (clr) begin
        m_run[ch]++;
        if (m_run[ch] == PERSIST) begin
          m_alarm[ch] = 1'b0;
          m_high[ch]  = 1'b0;
          m_run[ch]   = 0;
        end
      end else begin
        m_run[ch] = 0;
        if (abn) m_high[ch] = (t > HIGH_LIMIT);
      end
    end
  endtask

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic apply(input bit rst, input bit v, input int ch, input int t);
    logic [CHANNELS-1:0] old_alarm;
    rst_n             = !rst;
    bus.sampleValid   = v;
    bus.sampleChannel = 4'(ch);
    bus.temperature   = WIDTH'(t);
`ifdef TEMP_STICKY_ALARM_EN
    bus.ackMask = ack_drive;
`endif
    old_alarm = m_alarm;
    if (rst) begin
      model_reset();
    end else begin
      m_err = v && (ch >= CHANNELS);
      if (v && ch < CHANNELS) model_sample(ch, t);
`ifdef TEMP_STICKY_ALARM_EN
      m_sticky = (m_alarm & ~old_alarm) | (m_sticky & ~(ack_drive & ~old_alarm));
`endif
    end
    @(posedge clk);
    #1;
    check_value("alarm", 32'(bus.alarm), 32'(m_alarm));
    check_value("alarmHigh", 32'(bus.alarmHigh), 32'(m_high));
    check_value("anyAlarm", 32'(bus.anyAlarm), 32'(|m_alarm));
    check_value("sampleError", 32'(bus.sampleError), 32'(m_err));
`ifdef TEMP_STICKY_ALARM_EN
    check_value("stickyAlarm", 32'(bus.stickyAlarm), 32'(m_sticky));
`endif
    $display("txn rst=%0b v=%0b ch=%0d t=%0d alarm=%b high=%b any=%b err=%b",
             rst, v, ch, t, bus.alarm, bus.alarmHigh, bus.anyAlarm, bus.sampleError);
  endtask

  task automatic burst(input int ch, input int t, input int n);
    for (int k = 0; k < n; k++) apply(1'b0, 1'b1, ch, t);
  endtask

  initial begin
    int ch, t;
    bus.sampleValid   = 1'b0;
    bus.sampleChannel = 4'd0;
    bus.temperature   = '0;
`ifdef TEMP_STICKY_ALARM_EN
    bus.ackMask = '0;
`endif
    model_reset();

    // Reset state
    apply(1'b1, 1'b0, 0, 0);
    apply(1'b1, 1'b1, 0, 41);
    check_value("reset_alarm", 32'(bus.alarm), 32'd0);

    // 1: normal samples
    burst(0, 37, 2);

    // 2: high alarm on channel 1, then a broken streak
    burst(1, 41, 3);
    check_value("tp2_alarm1", 32'(bus.alarm[1]), 32'd1);
    check_value("tp2_high1", 32'(bus.alarmHigh[1]), 32'd1);
    burst(1, 37, 3);
    burst(1, 41, 2);
    apply(1'b0, 1'b1, 1, 37);
    check_value("tp2_no_alarm1", 32'(bus.alarm[1]), 32'd0);

    // 3: low alarm on channel 2, band sample interrupts clearing, cause flip
    burst(2, 33, 3);
    check_value("tp3_high2", 32'(bus.alarmHigh[2]), 32'd0);
    apply(1'b0, 1'b1, 2, 36);
    apply(1'b0, 1'b1, 2, 39);
    apply(1'b0, 1'b1, 2, 36);
    apply(1'b0, 1'b1, 2, 36);
    check_value("tp3_band_hold", 32'(bus.alarm[2]), 32'd1);
    burst(2, 36, 3);
    check_value("tp3_cleared", 32'(bus.alarm[2]), 32'd0);
    burst(2, 33, 3);
    apply(1'b0, 1'b1, 2, 36);
    apply(1'b0, 1'b1, 2, 41);
    check_value("tp3_flip", 32'(bus.alarmHigh[2]), 32'd1);

    // 4: interleaved channels 0 and 3, then an out-of-range tag
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 0, 30);
      apply(1'b0, 1'b1, 3, 30);
    end
    apply(1'b0, 1'b1, 5, 30);
    check_value("tp4_err", 32'(bus.sampleError), 32'd1);
    apply(1'b0, 1'b0, 0, 0);

    // 5: reset with channel 1 alarmed and a sample arriving
    burst(1, 41, 3);
    apply(1'b1, 1'b1, 1, 41);
    check_value("tp5_reset", 32'(bus.alarm), 32'd0);
    burst(1, 37, 3);

`ifdef TEMP_STICKY_ALARM_EN
    // 6: sticky alarm latch and acknowledge
    burst(0, 30, 3);
    ack_drive = 4'b0001;
    apply(1'b0, 1'b0, 0, 0);
    check_value("tp6_ack_ignored", 32'(bus.stickyAlarm[0]), 32'd1);
    ack_drive = '0;
    burst(0, 37, 3);
    check_value("tp6_sticky_held", 32'(bus.stickyAlarm[0]), 32'd1);
    ack_drive = 4'b0001;
    apply(1'b0, 1'b0, 0, 0);
    check_value("tp6_sticky_clr", 32'(bus.stickyAlarm[0]), 32'd0);
    ack_drive = '0;
`endif

    // Random traffic, biased toward the clear band and the limits
    for (int n = 0; n < 500; n++) begin
      ch = ($urandom_range(0, 9) == 0) ? $urandom_range(CHANNELS, 15) : $urandom_range(0, CHANNELS - 1);
      case ($urandom_range(0, 9))
        0:       t = ($urandom_range(0, 1) != 0) ? 0 : 255;
        1, 2, 3: t = $urandom_range(LOW_LIMIT + HYST, HIGH_LIMIT - HYST);
        default: t = $urandom_range(30, 44);
      endcase
`ifdef TEMP_STICKY_ALARM_EN
      ack_drive = CHANNELS'($urandom_range(0, 15) & $urandom_range(0, 15));
`endif
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, ch, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
